// File: rtl/seq101_rr_scheduler.sv
// Time-shares one overlapping "101" Moore detector across NCH serial channels.
// Per-channel state lives in a register file; a round-robin arbiter advances one channel per cycle.
module seq101_rr_scheduler #(
  parameter int  NCH  = 4,
  parameter int  CNTW = 8,
  localparam int CW   = ($clog2(NCH) > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NCH-1:0]  in_valid,
  input  logic [NCH-1:0]  in_bit,
  output logic [NCH-1:0]  in_ready,
  input  logic [NCH-1:0]  ch_clr,
  output logic            det_valid,
  output logic [CW-1:0]   det_ch,
  input  logic            det_ready,
  output logic [CNTW-1:0] match_cnt
);

  typedef enum logic [1:0] {
    ST_A = 2'b00,
    ST_B = 2'b01,
    ST_C = 2'b10,
    ST_D = 2'b11
  } state_e;

  state_e          state_q [NCH];
  state_e          state_d [NCH];
  logic [CW-1:0]   ptr_q, ptr_d;
  logic            det_valid_q, det_valid_d;
  logic [CW-1:0]   det_ch_q, det_ch_d;
  logic [CNTW-1:0] match_cnt_q, match_cnt_d;

  logic            free;
  logic [NCH-1:0]  elig;
  logic            grant_vld;
  logic [CW-1:0]   grant_ch;
  state_e          nxt;

  function automatic state_e next_state(input state_e s, input logic b);
    state_e r;
    unique case (s)
      ST_A:    r = b ? ST_B : ST_A;
      ST_B:    r = b ? ST_B : ST_C;
      ST_C:    r = b ? ST_D : ST_A;
      default: r = b ? ST_B : ST_C;
    endcase
    return r;
  endfunction

  // A channel being cleared is masked out, so the clear always beats a bit.
  always_comb begin
    free      = !det_valid_q || det_ready;
    elig      = in_valid & ~ch_clr;
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!grant_vld && elig[(int'(ptr_q) + k) % NCH]) begin
        grant_vld = 1'b1;
        grant_ch  = CW'((int'(ptr_q) + k) % NCH);
      end
    end
    if (reset || !free) begin
      grant_vld = 1'b0;
    end
    in_ready = '0;
    if (grant_vld) begin
      in_ready[grant_ch] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    det_valid_d = det_valid_q;
    det_ch_d    = det_ch_q;
    match_cnt_d = match_cnt_q;
    for (int i = 0; i < NCH; i++) begin
      if (ch_clr[i]) begin
        state_d[i] = ST_A;
      end
    end
    nxt = next_state(state_q[grant_ch], in_bit[grant_ch]);
    if (grant_vld) begin
      state_d[grant_ch] = nxt;
      ptr_d = (grant_ch == CW'(NCH - 1)) ? '0 : grant_ch + 1'b1;
    end
    // A new event may overwrite the slot only because free guarantees the old one was taken.
    if (grant_vld && nxt == ST_D) begin
      det_valid_d = 1'b1;
      det_ch_d    = grant_ch;
      if (match_cnt_q != '1) begin
        match_cnt_d = match_cnt_q + 1'b1;
      end
    end else if (det_ready) begin
      det_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_A;
      end
      ptr_q       <= '0;
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      det_valid_q <= det_valid_d;
      det_ch_q    <= det_ch_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign det_valid = det_valid_q;
  assign det_ch    = det_ch_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq101_rr_scheduler.sv
// Directed bench for seq101_rr_scheduler: expected events are queued by the stimulus
// and popped by an independent monitor on each det_valid/det_ready handshake.
module tb_seq101_rr_scheduler;

  localparam int NCH  = 4;
  localparam int CW   = 2;
  localparam int CNTW = 8;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [NCH-1:0]  in_valid;
  logic [NCH-1:0]  in_bit;
  logic [NCH-1:0]  in_ready;
  logic [NCH-1:0]  ch_clr;
  logic            det_valid;
  logic [CW-1:0]   det_ch;
  logic            det_ready;
  logic [CNTW-1:0] match_cnt;

  int checks = 0;
  int passes = 0;
  int exp_q[$];
  int exp_cnt = 0;

  seq101_rr_scheduler #(.NCH(NCH), .CNTW(CNTW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .ch_clr    (ch_clr),
    .det_valid (det_valid),
    .det_ch    (det_ch),
    .det_ready (det_ready),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!reset && det_valid && det_ready) begin
      if (exp_q.size() == 0) checkOutput("unexpected_event_ch", int'(det_ch), -1);
      else checkOutput("det_ch", int'(det_ch), exp_q.pop_front());
    end
  end

  task automatic resetDut();
    reset     = 1'b1;
    in_valid  = '1;
    in_bit    = '0;
    ch_clr    = '0;
    det_ready = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_in_reset", int'(in_ready), 0);
    @(posedge clk); #1;
    exp_q.delete();
    exp_cnt  = 0;
    reset    = 1'b0;
    in_valid = '0;
    checkOutput("reset_det_valid", int'(det_valid), 0);
    checkOutput("reset_det_ch", int'(det_ch), 0);
    checkOutput("reset_match_cnt", int'(match_cnt), 0);
  endtask

  // Called just after a posedge; sends one bit on a single channel and consumes it.
  task automatic applyStimulus(input int ch, input logic b, input logic exp_ev);
    in_valid     = '0;
    in_bit       = '0;
    in_valid[ch] = 1'b1;
    in_bit[ch]   = b;
    @(negedge clk);
    checkOutput("grant_onehot", int'(in_ready), 1 << ch);
    if (exp_ev) begin
      exp_q.push_back(ch);
      if (exp_cnt < CMAX) exp_cnt++;
    end
    @(posedge clk); #1;
    in_valid = '0;
    in_bit   = '0;
    if (det_ready) checkOutput("det_valid_latency", int'(det_valid), int'(exp_ev));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int rr_exp[5];
    rr_exp = '{1, 2, 4, 8, 1};
    resetDut();

    // T2: round-robin rotation with all channels requesting
    in_valid = '1;
    in_bit   = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("rr_rotation", int'(in_ready), rr_exp[i]);
      @(posedge clk); #1;
    end
    in_valid = '0;

    // T1: ch0 alone, 1,0,1,0,1
    applyStimulus(0, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 1'b1);
    applyStimulus(0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 1'b1);
    checkOutput("t1_match_cnt", int'(match_cnt), 2);

    // T3: interleaved histories, then back-to-back events replacing each other
    resetDut();
    applyStimulus(1, 1'b1, 1'b0);
    applyStimulus(2, 1'b1, 1'b0);
    applyStimulus(1, 1'b0, 1'b0);
    applyStimulus(2, 1'b1, 1'b0);
    applyStimulus(1, 1'b1, 1'b1);
    applyStimulus(2, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0);
    applyStimulus(2, 1'b1, 1'b1);
    applyStimulus(1, 1'b1, 1'b1);
    checkOutput("t3_match_cnt", int'(match_cnt), exp_cnt);

    // T4: stall while the event is held, then grants resume at ptr=1
    resetDut();
    applyStimulus(0, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 1'b0);
    det_ready = 1'b0;
    applyStimulus(0, 1'b1, 1'b1);
    checkOutput("t4_det_valid_set", int'(det_valid), 1);
    in_valid = '1;
    in_bit   = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t4_stall_in_ready", int'(in_ready), 0);
      checkOutput("t4_det_ch_hold", int'(det_ch), 0);
      checkOutput("t4_det_valid_hold", int'(det_valid), 1);
      @(posedge clk); #1;
    end
    det_ready = 1'b1;
    @(negedge clk);
    checkOutput("t4_resume_grant", int'(in_ready), 2);
    @(posedge clk); #1;
    in_valid = '0;
    checkOutput("t4_det_valid_clear", int'(det_valid), 0);

    // T5: clear beats a bit and restarts the channel history
    resetDut();
    applyStimulus(0, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 1'b0);
    ch_clr   = 4'b0001;
    in_valid = 4'b0011;
    in_bit   = 4'b0001;
    @(negedge clk);
    checkOutput("t5_clr_masks_grant", int'(in_ready), 2);
    @(posedge clk); #1;
    ch_clr   = '0;
    in_valid = '0;
    in_bit   = '0;
    applyStimulus(0, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 1'b1);

    // T6: reset drops a pending event and partial sequences
    resetDut();
    applyStimulus(3, 1'b1, 1'b0);
    applyStimulus(3, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 1'b0);
    det_ready = 1'b0;
    applyStimulus(0, 1'b1, 1'b1);
    checkOutput("t6_pending_before_reset", int'(det_valid), 1);
    resetDut();
    applyStimulus(3, 1'b1, 1'b0);
    checkOutput("t6_match_cnt", int'(match_cnt), 0);

    // Counter saturation at all-ones
    resetDut();
    applyStimulus(2, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(2, 1'b0, 1'b0);
      applyStimulus(2, 1'b1, 1'b1);
    end
    checkOutput("sat_match_cnt", int'(match_cnt), exp_cnt);
    checkOutput("sat_match_cnt_max", int'(match_cnt), CMAX);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("events_outstanding", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
